// File: rtl/uge_arb_pkg.sv
// ----------------------------------------------------------------------------
// uge_arb_pkg
// Shared types and helpers for the uge_share_arb comparator-sharing arbiter.
//   rsp_state_t : response-stage occupancy (RSP_EMPTY / RSP_FULL)
//   GRANT_CNT_W : width of the optional accepted-request counter
//   rr_pick()   : round-robin search over a zero-extended valid vector,
//                 returning a found flag and the winning index
// ----------------------------------------------------------------------------
package uge_arb_pkg;

    localparam int GRANT_CNT_W = 16;

    // rr_pick works on a fixed-size view so it can live in a package;
    // callers zero-extend their vectors and pass the real requester count.
    localparam int RR_MAX_REQ = 64;
    localparam int RR_IDX_W   = 6;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First valid index at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [RR_IDX_W-1:0]   ptr,
        input int                    n
    );
        rr_pick_t res;
        int       idx;
        res = '0;
        for (int k = 0; k < RR_MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !res.found && valid[idx]) begin
                res.found = 1'b1;
                res.idx   = idx[RR_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uge_cmp.sv
// ----------------------------------------------------------------------------
// uge_cmp
// Purely combinational unsigned greater-or-equal comparator.
//   I0, I1 : WIDTH-bit unsigned operands
//   O      : 1 when I0 >= I1
// ----------------------------------------------------------------------------
module uge_cmp #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    output logic             O
);

    assign O = (I0 >= I1);

endmodule

// File: rtl/uge_share_arb.sv
// ----------------------------------------------------------------------------
// uge_share_arb
// Round-robin arbiter that shares a single uge_cmp among N_REQ requesters and
// registers each result, tagged with the requester ID, in a one-entry
// valid/ready response stage.
//   CLK, ASYNCRESETN  : clock, asynchronous active-low reset
//   REQ_VALID/READY   : per-requester handshake (READY is one-hot or zero)
//   REQ_A, REQ_B      : packed operands, requester i at [i*WIDTH +: WIDTH]
//   RSP_VALID/READY   : response handshake
//   RSP_ID, RSP_GE    : winner index and (A >= B) result
//   GRANT_CNT         : saturating transfer count, only when
//                       UGE_ARB_STATS_EN is defined
// ----------------------------------------------------------------------------
module uge_share_arb
    import uge_arb_pkg::*;
#(
    parameter  int WIDTH = 2,
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    input  logic [N_REQ-1:0]       REQ_VALID,
    output logic [N_REQ-1:0]       REQ_READY,
    input  logic [N_REQ*WIDTH-1:0] REQ_A,
    input  logic [N_REQ*WIDTH-1:0] REQ_B,
    output logic                   RSP_VALID,
    input  logic                   RSP_READY,
    output logic [ID_W-1:0]        RSP_ID,
    output logic                   RSP_GE
`ifdef UGE_ARB_STATS_EN
    ,
    output logic [GRANT_CNT_W-1:0] GRANT_CNT
`endif
);

    rsp_state_t      state_reg, state_next;
    logic [ID_W-1:0] rsp_id_reg, rsp_id_next;
    logic            rsp_ge_reg, rsp_ge_next;
    logic [ID_W-1:0] ptr_reg, ptr_next;

    logic [WIDTH-1:0] a_arr [N_REQ];
    logic [WIDTH-1:0] b_arr [N_REQ];

    logic [RR_MAX_REQ-1:0] valid_ext;
    logic [RR_IDX_W-1:0]   ptr_ext;
    rr_pick_t              pick;
    logic                  can_accept;
    logic [N_REQ-1:0]      grant;
    logic                  xfer;
    logic [ID_W-1:0]       grant_id;
    logic [WIDTH-1:0]      sel_a, sel_b;
    logic                  cmp_ge;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign a_arr[gi] = REQ_A[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = REQ_B[gi*WIDTH +: WIDTH];
            assign grant[gi] = can_accept && pick.found && (pick.idx == RR_IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = REQ_VALID;
        ptr_ext                = '0;
        ptr_ext[ID_W-1:0]      = ptr_reg;
        pick                   = rr_pick(valid_ext, ptr_ext, N_REQ);
    end

    // Reset is folded in so no requester sees READY while held in reset,
    // even though the state register already reads EMPTY then.
    assign can_accept = ASYNCRESETN && ((state_reg == RSP_EMPTY) || RSP_READY);
    assign xfer       = |grant;
    assign REQ_READY  = grant;

    // One-hot grant drives both the ID encoder and an AND-OR operand mux.
    always_comb begin
        grant_id = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                grant_id = grant_id | ID_W'(k);
            end
            sel_a = sel_a | (a_arr[k] & {WIDTH{grant[k]}});
            sel_b = sel_b | (b_arr[k] & {WIDTH{grant[k]}});
        end
    end

    uge_cmp #(.WIDTH(WIDTH)) u_cmp (
        .I0 (sel_a),
        .I1 (sel_b),
        .O  (cmp_ge)
    );

    always_comb begin
        state_next  = state_reg;
        rsp_id_next = rsp_id_reg;
        rsp_ge_next = rsp_ge_reg;
        ptr_next    = ptr_reg;
        if (xfer) begin
            state_next  = RSP_FULL;
            rsp_id_next = grant_id;
            rsp_ge_next = cmp_ge;
            ptr_next    = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end else if ((state_reg == RSP_FULL) && RSP_READY) begin
            // Pop only: ID/GE keep their stale values behind RSP_VALID=0.
            state_next = RSP_EMPTY;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_reg  <= RSP_EMPTY;
            rsp_id_reg <= '0;
            rsp_ge_reg <= 1'b0;
            ptr_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            rsp_id_reg <= rsp_id_next;
            rsp_ge_reg <= rsp_ge_next;
            ptr_reg    <= ptr_next;
        end
    end

    assign RSP_VALID = (state_reg == RSP_FULL);
    assign RSP_ID    = rsp_id_reg;
    assign RSP_GE    = rsp_ge_reg;

`ifdef UGE_ARB_STATS_EN
    logic [GRANT_CNT_W-1:0] grant_cnt_reg;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            grant_cnt_reg <= '0;
        end else if (xfer && (grant_cnt_reg != '1)) begin
            grant_cnt_reg <= grant_cnt_reg + GRANT_CNT_W'(1);
        end
    end

    assign GRANT_CNT = grant_cnt_reg;
`endif

endmodule

// File: tb/tb_uge_share_arb.sv
// ----------------------------------------------------------------------------
// tb_uge_share_arb
// Directed bench for uge_share_arb (WIDTH=2, N_REQ=4). Inputs change 1 time
// unit after a rising edge; combinational READY is sampled 1 unit later and
// registered outputs 1 unit after the following edge. Define
// UGE_ARB_STATS_EN to also exercise the saturating grant counter.
// ----------------------------------------------------------------------------
module tb_uge_share_arb;

    logic       CLK = 1'b0;
    logic       ASYNCRESETN;
    logic [3:0] REQ_VALID;
    logic [3:0] REQ_READY;
    logic [7:0] REQ_A;
    logic [7:0] REQ_B;
    logic       RSP_VALID;
    logic       RSP_READY;
    logic [1:0] RSP_ID;
    logic       RSP_GE;
`ifdef UGE_ARB_STATS_EN
    logic [15:0] GRANT_CNT;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    uge_share_arb #(.WIDTH(2), .N_REQ(4)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .REQ_VALID   (REQ_VALID),
        .REQ_READY   (REQ_READY),
        .REQ_A       (REQ_A),
        .REQ_B       (REQ_B),
        .RSP_VALID   (RSP_VALID),
        .RSP_READY   (RSP_READY),
        .RSP_ID      (RSP_ID),
        .RSP_GE      (RSP_GE)
`ifdef UGE_ARB_STATS_EN
        ,
        .GRANT_CNT   (GRANT_CNT)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        ASYNCRESETN = 1'b0;
        REQ_VALID   = '0;
        tick();
        tick();
        ASYNCRESETN = 1'b1;
    endtask

    // Round-robin operand set: req0 0>=0 ->1, req1 1>=2 ->0,
    // req2 3>=1 ->1, req3 2>=3 ->0.
    localparam logic [7:0] RR_A  = {2'd2, 2'd3, 2'd1, 2'd0};
    localparam logic [7:0] RR_B  = {2'd3, 2'd1, 2'd2, 2'd0};
    logic [3:0] rr_ge;
    int         rr_order [6];

    initial begin
        rr_ge    = 4'b0101;
        rr_order = '{0, 1, 2, 3, 0, 1};

        // ---------------- reset state ----------------
        ASYNCRESETN = 1'b0;
        REQ_VALID   = 4'b1111;
        REQ_A       = RR_A;
        REQ_B       = RR_B;
        RSP_READY   = 1'b1;
        #3;
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("rst_req_ready", 32'(REQ_READY), 32'd0);
        chk("rst_rsp_id",    32'(RSP_ID),    32'd0);
`ifdef UGE_ARB_STATS_EN
        chk("rst_grant_cnt", 32'(GRANT_CNT), 32'd0);
`endif
        tick();
        chk("rst_hold_ready", 32'(REQ_READY), 32'd0);
        REQ_VALID   = '0;
        ASYNCRESETN = 1'b1;

        // ---------------- single requester ----------------
        REQ_VALID = 4'b0010;
        REQ_A     = {2'd0, 2'd0, 2'd2, 2'd0};
        REQ_B     = {2'd0, 2'd0, 2'd3, 2'd0};
        #1;
        chk("single1_ready", 32'(REQ_READY), 32'b0010);
        tick();
        chk("single1_valid", 32'(RSP_VALID), 32'd1);
        chk("single1_id",    32'(RSP_ID),    32'd1);
        chk("single1_ge",    32'(RSP_GE),    32'd0);
        REQ_A = {2'd0, 2'd0, 2'd3, 2'd0};
        #1;
        chk("single2_ready", 32'(REQ_READY), 32'b0010);
        tick();
        chk("single2_valid", 32'(RSP_VALID), 32'd1);
        chk("single2_id",    32'(RSP_ID),    32'd1);
        chk("single2_ge",    32'(RSP_GE),    32'd1);
        REQ_VALID = '0;
        tick();
        chk("single_drain", 32'(RSP_VALID), 32'd0);
        chk("single_stale_ge", 32'(RSP_GE), 32'd1);

        // ---------------- round robin ----------------
        do_reset();
        REQ_A     = RR_A;
        REQ_B     = RR_B;
        REQ_VALID = 4'b1111;
        RSP_READY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr%0d_ready", i), 32'(REQ_READY), 32'(4'b0001 << rr_order[i]));
            tick();
            chk($sformatf("rr%0d_valid", i), 32'(RSP_VALID), 32'd1);
            chk($sformatf("rr%0d_id", i),    32'(RSP_ID),    32'(rr_order[i]));
            chk($sformatf("rr%0d_ge", i),    32'(RSP_GE),    32'(rr_ge[rr_order[i]]));
        end
        REQ_VALID = '0;
        tick();
        chk("rr_drain", 32'(RSP_VALID), 32'd0);

        // ---------------- backpressure (pointer now at 2) ----------------
        REQ_VALID = 4'b1111;
        RSP_READY = 1'b0;
        #1;
        chk("bp_first_ready", 32'(REQ_READY), 32'b0100);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_ready", i), 32'(REQ_READY), 32'd0);
            chk($sformatf("bp%0d_valid", i), 32'(RSP_VALID), 32'd1);
            chk($sformatf("bp%0d_id", i),    32'(RSP_ID),    32'd2);
            chk($sformatf("bp%0d_ge", i),    32'(RSP_GE),    32'd1);
            tick();
        end
        RSP_READY = 1'b1;
        #1;
        chk("bp_release_ready", 32'(REQ_READY), 32'b1000);
        tick();
        chk("bp_next_id", 32'(RSP_ID), 32'd3);
        chk("bp_next_ge", 32'(RSP_GE), 32'd0);
        REQ_VALID = '0;
        tick();
        chk("bp_drain", 32'(RSP_VALID), 32'd0);

        // ---------------- wrap and skip ----------------
        // Pointer is 0; one grant to req2 moves it to 3.
        REQ_VALID = 4'b0100;
        tick();
        chk("wrap_setup_id", 32'(RSP_ID), 32'd2);
        REQ_VALID = 4'b0101;
        #1;
        chk("wrap_ready0", 32'(REQ_READY), 32'b0001);
        tick();
        chk("wrap_id0", 32'(RSP_ID), 32'd0);
        chk("wrap_ge0", 32'(RSP_GE), 32'd1);
        REQ_VALID = 4'b0100;
        #1;
        chk("wrap_ready2", 32'(REQ_READY), 32'b0100);
        tick();
        chk("wrap_id2", 32'(RSP_ID), 32'd2);

        // ---------------- asynchronous reset while FULL ----------------
        REQ_VALID = '0;
        RSP_READY = 1'b0;
        #2;
        chk("arst_pre_valid", 32'(RSP_VALID), 32'd1);
        ASYNCRESETN = 1'b0;
        #1;
        chk("arst_valid", 32'(RSP_VALID), 32'd0);
        chk("arst_id",    32'(RSP_ID),    32'd0);
        chk("arst_ge",    32'(RSP_GE),    32'd0);
        tick();
        ASYNCRESETN = 1'b1;
        RSP_READY   = 1'b1;

`ifdef UGE_ARB_STATS_EN
        // ---------------- saturating grant counter ----------------
        do_reset();
        REQ_A     = RR_A;
        REQ_B     = RR_B;
        REQ_VALID = 4'b1111;
        RSP_READY = 1'b1;
        repeat (70000) @(posedge CLK);
        #1;
        chk("stats_sat", 32'(GRANT_CNT), 32'hFFFF);
        repeat (3) @(posedge CLK);
        #1;
        chk("stats_hold", 32'(GRANT_CNT), 32'hFFFF);
        REQ_VALID = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uge_share_arb.md
# uge_share_arb

Round-robin arbiter and sequencer that shares one unsigned greater-or-equal comparator among N requesters. Each cycle it grants at most one requester, drives the granted operand pair through the shared comparator, and registers the 1-bit result with the winner's ID into a one-entry response stage with valid/ready backpressure. It sits between a set of compare clients and a single comparator instance, so the comparator is not replicated per client.

## Interface
- WIDTH, default 2: operand width in bits; must be at least 1.
- N_REQ, default 4: number of requesters; must be at least 2.
- ID_W, default $clog2(N_REQ): width of the requester ID (derived; not overridden).

Ports:
- CLK  in  1  the single clock; all state updates on its rising edge.
- ASYNCRESETN  in  1  reset, asynchronous assert, active-low.
- REQ_VALID  in  N_REQ  per-requester request valid.
- REQ_READY  out  N_REQ  per-requester grant; one-hot or zero.
- REQ_A  in  N_REQ*WIDTH  packed first operands; requester i owns bits [i*WIDTH +: WIDTH].
- REQ_B  in  N_REQ*WIDTH  packed second operands; same packing as REQ_A.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response consumer ready.
- RSP_ID  out  ID_W  index of the requester this response belongs to.
- RSP_GE  out  1  1 when A >= B (unsigned), else 0.
- GRANT_CNT  out  16  saturating count of accepted requests; present only with UGE_ARB_STATS_EN.

## Operation
- Response stage has two states:
  - EMPTY: RSP_VALID=0.
  - FULL: RSP_VALID=1.
- can_accept = EMPTY | (FULL & RSP_READY).
- When can_accept=1, the arbiter grants the first requester with REQ_VALID=1, searching from index PTR upward and wrapping modulo N_REQ. REQ_READY of that requester alone is 1.
- When can_accept=0 or no requester is valid, REQ_READY is all zeros.
- A transfer happens on a cycle where REQ_VALID[i] and REQ_READY[i] are both 1. On that edge:
  - RSP_ID <= i.
  - RSP_GE <= (A_i >= B_i), a full-width unsigned compare with no sign extension.
  - State becomes FULL.
  - PTR <= (i+1) mod N_REQ.
- FULL & RSP_READY with no new transfer: state becomes EMPTY; RSP_ID and RSP_GE hold their stale values.
- FULL & !RSP_READY: RSP_VALID, RSP_ID and RSP_GE are held stable. No grant is issued.
- FULL & RSP_READY together with a new transfer: pop and push occur on the same edge, sustaining 1 response per cycle.
- PTR changes only on a transfer. A requester that is valid but not granted keeps its priority position.
- Requesters must hold REQ_VALID, REQ_A and REQ_B stable until granted. REQ_VALID must not depend combinationally on REQ_READY.
- Reset (asynchronous, mid-operation included):
  - State EMPTY, RSP_VALID=0, RSP_ID=0, RSP_GE=0, PTR=0, GRANT_CNT=0.
  - REQ_READY is 0 while ASYNCRESETN=0.
  - Any held response is discarded.

## Timing
- REQ_READY is combinational from REQ_VALID, PTR, state and RSP_READY.
- Result latency is 1 cycle: a transfer at edge t gives RSP_VALID=1 from t+1 onward.
- Throughput is 1 compare per cycle while RSP_READY=1.
- With all requesters continuously valid, each requester is granted exactly once every N_REQ transfers.
- The compare path is combinational from REQ_A/REQ_B through the grant mux to the RSP_GE register. There is no other pipelining.

## Configuration
- UGE_ARB_STATS_EN defined:
  - GRANT_CNT port and register exist.
  - GRANT_CNT increments by 1 on each transfer and saturates at 16'hFFFF.
  - GRANT_CNT resets to 0.
- UGE_ARB_STATS_EN undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

## Structure
- Package uge_arb_pkg holds:
  - the response-state enum (RSP_EMPTY, RSP_FULL);
  - the constant GRANT_CNT_W=16;
  - a function rr_pick(valid, ptr) that returns the found flag and the index.
- One sub-module, uge_cmp: parameter WIDTH, inputs I0 and I1, output O = (I0 >= I1) unsigned, purely combinational.
- uge_cmp is instantiated once, fed by the grant-selected operands.

## Test plan
All scenarios use WIDTH=2 and N_REQ=4.
- Reset check: ASYNCRESETN=0 → RSP_VALID=0, REQ_READY=0000, GRANT_CNT=0. Then assert reset asynchronously while FULL → RSP_VALID drops immediately, without a clock edge.
- Single requester: req1 with A=2, B=3, then A=3, B=3, RSP_READY=1 → responses ID=1 GE=0, then ID=1 GE=1, each 1 cycle after its grant.
- Round-robin: all four requesters valid with fixed operands, RSP_READY=1 → grant order 0,1,2,3,0,1 and one response per cycle.
- Backpressure: FULL with RSP_READY=0 for 3 cycles → REQ_READY=0000 and RSP_ID/RSP_GE stable. Then set RSP_READY=1 → next grant is issued in the same cycle.
- Wrap and skip: PTR=3, only req0 and req2 valid → req0 granted, then req2.
- Stats (macro defined): 70000 back-to-back transfers → GRANT_CNT=16'hFFFF, held there.
